// File: rtl/data_mem_responder_if.sv
// Request/response bus between the CPU MEM stage and the data-memory responder.
// The master side is the requesting core; the slave side is the responder.
interface data_mem_responder_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_wmask_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        busy_o;

    modport slave (
        input  req_valid_i,
        input  req_write_i,
        input  req_addr_i,
        input  req_wdata_i,
        input  req_wmask_i,
        output req_ready_o,
        output resp_valid_o,
        output resp_rdata_o,
        output resp_err_o,
        output busy_o
    );

    modport master (
        output req_valid_i,
        output req_write_i,
        output req_addr_i,
        output req_wdata_i,
        output req_wmask_i,
        input  req_ready_o,
        input  resp_valid_o,
        input  resp_rdata_o,
        input  resp_err_o,
        input  busy_o
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: takes one load/store at a time, waits
// LATENCY cycles, commits the word access with byte-lane enables and returns
// a one-cycle response. busy_o lets the core stall while an access is pending.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    data_mem_responder_if.slave bus
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT4    = 4'(LATENCY);
    localparam logic [29:0] DEPTH30 = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  waitCnt_q;
    logic        ready_q;
    logic        respValid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        holdWrite_q;
    logic [31:0] holdAddr_q;
    logic [31:0] holdWdata_q;
    logic [3:0]  holdMask_q;

    logic [31:0] memWords_q [DEPTH_WORDS];

    logic          accept;
    logic          commitNow;
    logic          cWrite;
    logic [31:0]   cAddr;
    logic [31:0]   cWdata;
    logic [3:0]    cMask;
    logic          cErr;
    logic [AW-1:0] cIdx;
    logic [31:0]   readWord;
    logic [31:0]   rdata_d;
    logic          err_d;

    // Choose the operands of the access being committed this edge: the live bus
    // when a zero-latency request commits on its accept edge, otherwise the
    // values captured at accept time.
    always_comb begin
        accept    = bus.req_valid_i && ready_q;
        commitNow = 1'b0;
        cWrite    = holdWrite_q;
        cAddr     = holdAddr_q;
        cWdata    = holdWdata_q;
        cMask     = holdMask_q;
        if (state_q == IDLE) begin
            cWrite    = bus.req_write_i;
            cAddr     = bus.req_addr_i;
            cWdata    = bus.req_wdata_i;
            cMask     = bus.req_wmask_i;
            commitNow = accept && (LAT4 == 4'd0);
        end else if (state_q == WAIT) begin
            commitNow = (waitCnt_q == 4'd1);
        end
        cErr = (cAddr[1:0] != 2'b00) || (cAddr[31:2] >= DEPTH30);
        cIdx = cAddr[AW+1:2];
    end

    // Work out the response payload that a commit on this edge will register.
    always_comb begin
        readWord = memWords_q[cIdx];
        rdata_d  = 32'd0;
        err_d    = cErr;
        if (!cErr && !cWrite) begin
            rdata_d = readWord;
        end
    end

    // Storage array with byte-lane writes; never reset, and writes are blocked
    // while reset is held so an access cannot slip in during reset.
    always_ff @(posedge clk_i) begin
        if (rst_i && commitNow && cWrite && !cErr) begin
            for (int b = 0; b < 4; b++) begin
                if (cMask[b]) begin
                    memWords_q[cIdx][8*b +: 8] <= cWdata[8*b +: 8];
                end
            end
        end
    end

    // Request sequencer: IDLE accepts and captures, WAIT counts down the
    // latency, RESP presents the response for one cycle before reopening.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            waitCnt_q   <= 4'd0;
            ready_q     <= 1'b1;
            respValid_q <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            holdWrite_q <= 1'b0;
            holdAddr_q  <= 32'd0;
            holdWdata_q <= 32'd0;
            holdMask_q  <= 4'd0;
        end else begin
            if (commitNow) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        holdWrite_q <= bus.req_write_i;
                        holdAddr_q  <= bus.req_addr_i;
                        holdWdata_q <= bus.req_wdata_i;
                        holdMask_q  <= bus.req_wmask_i;
                        waitCnt_q   <= LAT4;
                        ready_q     <= 1'b0;
                        if (LAT4 == 4'd0) begin
                            state_q     <= RESP;
                            respValid_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    waitCnt_q <= waitCnt_q - 4'd1;
                    if (waitCnt_q == 4'd1) begin
                        state_q     <= RESP;
                        respValid_q <= 1'b1;
                    end
                end
                RESP: begin
                    respValid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    respValid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    waitCnt_q   <= 4'd0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o  = ready_q;
    assign bus.busy_o       = ~ready_q;
    assign bus.resp_valid_o = respValid_q;
    assign bus.resp_rdata_o = rdata_q;
    assign bus.resp_err_o   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance at LATENCY=2 for the
// functional, error and reset scenarios, one at LATENCY=0 for back-to-back.
module tb_data_mem_responder;

    logic clock;
    logic resetN;

    int vectorCount;
    int missCount;

    data_mem_responder_if bus2 ();
    data_mem_responder_if bus0 ();

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut2 (
        .clk_i (clock),
        .rst_i (resetN),
        .bus   (bus2)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
        .clk_i (clock),
        .rst_i (resetN),
        .bus   (bus0)
    );

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    vec_t v0 [7];

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One request on the LATENCY=2 instance, observed for 6 cycles after accept.
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] m, input bit scramble,
                                 output logic [31:0] rd, output logic er,
                                 output int lat, output int busyN, output int respN);
        lat   = -1;
        busyN = 0;
        respN = 0;
        rd    = 32'd0;
        er    = 1'b0;
        @(negedge clock);
        checkOutput("ready_before_req", 32'(bus2.req_ready_o), 32'd1);
        bus2.req_valid_i = 1'b1;
        bus2.req_write_i = w;
        bus2.req_addr_i  = a;
        bus2.req_wdata_i = d;
        bus2.req_wmask_i = m;
        @(posedge clock);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            if (c == 1) begin
                bus2.req_valid_i = 1'b0;
                if (scramble) begin
                    bus2.req_write_i = 1'b1;
                    bus2.req_addr_i  = 32'h0;
                    bus2.req_wdata_i = 32'hFFFF_FFFF;
                    bus2.req_wmask_i = 4'hF;
                end
            end
            if (bus2.busy_o === 1'b1) busyN++;
            if (bus2.resp_valid_o === 1'b1) begin
                respN++;
                if (lat < 0) begin
                    lat = c;
                    rd  = bus2.resp_rdata_o;
                    er  = bus2.resp_err_o;
                end
            end
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          busyN;
    int          respN;

    // Directed scenario sequence.
    initial begin
        int idx;
        int respSeen;
        vectorCount = 0;
        missCount   = 0;
        resetN      = 1'b0;
        bus2.req_valid_i = 1'b0; bus2.req_write_i = 1'b0; bus2.req_addr_i = '0;
        bus2.req_wdata_i = '0;   bus2.req_wmask_i = '0;
        bus0.req_valid_i = 1'b0; bus0.req_write_i = 1'b0; bus0.req_addr_i = '0;
        bus0.req_wdata_i = '0;   bus0.req_wmask_i = '0;

        v0[0] = '{1'b1, 32'h0000_03FC, 32'h1234_5678, 4'hF, 32'h0,         1'b0};
        v0[1] = '{1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
        v0[2] = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
        v0[3] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
        v0[4] = '{1'b0, 32'h0000_03FC, 32'h0,         4'h0, 32'h1234_5678, 1'b0};
        v0[5] = '{1'b0, 32'h0000_0400, 32'h0,         4'h0, 32'h0,         1'b1};
        v0[6] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0,         1'b1};

        repeat (2) @(negedge clock);
        checkOutput("rst_ready", 32'(bus2.req_ready_o), 32'd1);
        checkOutput("rst_busy",  32'(bus2.busy_o),      32'd0);
        checkOutput("rst_rvld",  32'(bus2.resp_valid_o), 32'd0);
        checkOutput("rst_rdata", bus2.resp_rdata_o,     32'd0);
        checkOutput("rst_err",   32'(bus2.resp_err_o),  32'd0);
        resetN = 1'b1;

        $display("[TB] full-word store and load, LATENCY=2");
        applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, er, lat, busyN, respN);
        checkOutput("st_lat",   32'(lat),   32'd3);
        checkOutput("st_busy",  32'(busyN), 32'd3);
        checkOutput("st_resps", 32'(respN), 32'd1);
        checkOutput("st_rdata", rd,         32'd0);
        checkOutput("st_err",   32'(er),    32'd0);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, lat, busyN, respN);
        checkOutput("ld_lat",   32'(lat),   32'd3);
        checkOutput("ld_busy",  32'(busyN), 32'd3);
        checkOutput("ld_rdata", rd,         32'hDEAD_BEEF);
        checkOutput("ld_err",   32'(er),    32'd0);

        $display("[TB] partial byte-lane store");
        applyStimulus(1'b1, 32'h10, 32'h0000_00AA, 4'h1, 1'b0, rd, er, lat, busyN, respN);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, lat, busyN, respN);
        checkOutput("part_rdata", rd, 32'hDEAD_BEAA);

        $display("[TB] misaligned and out-of-range accesses");
        applyStimulus(1'b0, 32'h12, 32'h0, 4'h0, 1'b0, rd, er, lat, busyN, respN);
        checkOutput("misal_err",   32'(er), 32'd1);
        checkOutput("misal_rdata", rd,      32'd0);
        applyStimulus(1'b1, 32'h0, 32'h5A5A_5A5A, 4'hF, 1'b0, rd, er, lat, busyN, respN);
        applyStimulus(1'b1, 32'h400, 32'h0000_0BAD, 4'hF, 1'b0, rd, er, lat, busyN, respN);
        checkOutput("oor_err",  32'(er),    32'd1);
        checkOutput("oor_lat",  32'(lat),   32'd3);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, rd, er, lat, busyN, respN);
        checkOutput("oor_word0", rd, 32'h5A5A_5A5A);

        $display("[TB] request fields change during WAIT");
        applyStimulus(1'b1, 32'h30, 32'h7766_5544, 4'hF, 1'b1, rd, er, lat, busyN, respN);
        checkOutput("scr_resps", 32'(respN), 32'd1);
        checkOutput("scr_err",   32'(er),    32'd0);
        applyStimulus(1'b0, 32'h30, 32'h0, 4'h0, 1'b0, rd, er, lat, busyN, respN);
        checkOutput("scr_word30", rd, 32'h7766_5544);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, rd, er, lat, busyN, respN);
        checkOutput("scr_word0", rd, 32'h5A5A_5A5A);

        $display("[TB] reset during WAIT of a store");
        applyStimulus(1'b1, 32'h20, 32'h1111_1111, 4'hF, 1'b0, rd, er, lat, busyN, respN);
        applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd, er, lat, busyN, respN);
        checkOutput("pre_rst_rdata", rd, 32'h1111_1111);
        @(negedge clock);
        bus2.req_valid_i = 1'b1;
        bus2.req_write_i = 1'b1;
        bus2.req_addr_i  = 32'h20;
        bus2.req_wdata_i = 32'h2222_2222;
        bus2.req_wmask_i = 4'hF;
        @(posedge clock);
        @(negedge clock);
        bus2.req_valid_i = 1'b0;
        checkOutput("wait_busy", 32'(bus2.busy_o), 32'd1);
        resetN = 1'b0;
        #1;
        checkOutput("mid_rst_ready", 32'(bus2.req_ready_o),  32'd1);
        checkOutput("mid_rst_busy",  32'(bus2.busy_o),       32'd0);
        checkOutput("mid_rst_rvld",  32'(bus2.resp_valid_o), 32'd0);
        checkOutput("mid_rst_rdata", bus2.resp_rdata_o,      32'd0);
        checkOutput("mid_rst_err",   32'(bus2.resp_err_o),   32'd0);
        respSeen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (c == 2) resetN = 1'b1;
            if (bus2.resp_valid_o !== 1'b0) respSeen++;
        end
        checkOutput("mid_rst_noresp", 32'(respSeen), 32'd0);
        applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd, er, lat, busyN, respN);
        checkOutput("post_rst_word20", rd, 32'h1111_1111);

        $display("[TB] back-to-back requests, LATENCY=0");
        idx = 0;
        @(negedge clock);
        bus0.req_valid_i = 1'b1;
        bus0.req_write_i = v0[0].w;
        bus0.req_addr_i  = v0[0].a;
        bus0.req_wdata_i = v0[0].d;
        bus0.req_wmask_i = v0[0].m;
        @(posedge clock);
        for (int c = 1; c <= 20 && idx < 7; c++) begin
            @(negedge clock);
            if (bus0.resp_valid_o === 1'b1) begin
                checkOutput("l0_slot",  32'(c), 32'(2 * idx + 1));
                checkOutput("l0_rdata", bus0.resp_rdata_o, v0[idx].rd);
                checkOutput("l0_err",   32'(bus0.resp_err_o), 32'(v0[idx].er));
                idx++;
                if (idx < 7) begin
                    bus0.req_write_i = v0[idx].w;
                    bus0.req_addr_i  = v0[idx].a;
                    bus0.req_wdata_i = v0[idx].d;
                    bus0.req_wmask_i = v0[idx].m;
                end else begin
                    bus0.req_valid_i = 1'b0;
                end
            end else begin
                checkOutput("l0_ready_gap", 32'(bus0.req_ready_o), 32'd1);
            end
        end
        checkOutput("l0_count", 32'(idx), 32'd7);
        @(negedge clock);
        checkOutput("l0_tail_rvld", 32'(bus0.resp_valid_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder serving the load/store requests the pipelined CPU issues from its MEM stage. Accepts one request at a time over a valid/ready handshake, waits a programmable number of cycles, and performs the word access with byte-lane write enables. Returns a single-cycle response carrying read data and an error flag. Its busy indication lets the core stall its pipeline while an access is outstanding.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, 4..65536.
- LATENCY, 2: wait cycles inserted between accept and commit; 0..15.

- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  responder can accept a request this cycle.
- req_write_i  input  1  1 = store, 0 = load.
- req_addr_i  input  32  byte address.
- req_wdata_i  input  32  store data.
- req_wmask_i  input  4  byte-lane enables; bit n covers bits [8n+7:8n].
- resp_valid_o  output  1  response valid, exactly one cycle per accepted request.
- resp_rdata_o  output  32  load data; 0 for stores and errors.
- resp_err_o  output  1  request was misaligned or out of range.
- busy_o  output  1  a request is outstanding; equals ~req_ready_o.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o = 1.
  - Accept when req_valid_i && req_ready_o at a rising edge.
  - On accept, capture write, addr, wdata and wmask into holding registers. Later input changes are ignored.
  - Load a 4-bit wait counter with LATENCY.
  - Next state is WAIT if LATENCY > 0; otherwise commit on this same edge and go to RESP.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter = 1, commit on that edge and go to RESP.
- Commit (single edge):
  - Error when addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS.
  - Error: no array write, rdata register = 0, err register = 1.
  - Store: write lanes with wmask bit set at word addr[31:2]; rdata = 0, err = 0. wmask = 0 is a legal no-op that still responds.
  - Load: rdata = word at addr[31:2], err = 0.
- RESP:
  - resp_valid_o = 1 for exactly one cycle, with resp_rdata_o and resp_err_o stable. The requester always consumes it; there is no response backpressure.
  - Then go to IDLE. No request is accepted while in RESP.
- Array contents are not reset. Reads of never-written words return X in simulation.
- resp_rdata_o and resp_err_o hold their last values outside RESP. Consumers must qualify them with resp_valid_o.

## Timing
- Reset (rst_i low, asynchronous):
  - State → IDLE, counter = 0.
  - req_ready_o = 1, busy_o = 0, resp_valid_o = 0, resp_rdata_o = 0, resp_err_o = 0.
- Reset mid-operation:
  - An uncommitted request is dropped with no array write and no response.
  - A request already committed keeps its write, but its response is suppressed.
- Latency: accept on edge k → resp_valid_o high during cycle k+1+LATENCY.
- Throughput: one request per LATENCY+2 cycles. req_ready_o is low from the cycle after accept through the RESP cycle.
- req_valid_i asserted in WAIT or RESP is not accepted. The requester must hold it, and it is taken in the first IDLE cycle.
- The address range check uses the full 32-bit address; there is no wrap-around of the word index.

## Test plan
- Reset, then LATENCY=2: store 0xDEADBEEF to 0x10 with mask 0xF, then load 0x10.
  - Each response arrives 3 cycles after accept.
  - Load returns 0xDEADBEEF with err = 0.
  - busy_o is high exactly 3 cycles per request.
- Partial write: after the above, store 0x000000AA to 0x10 with mask 0x1; load 0x10 → 0xDEADBEAA.
- Errors (DEPTH_WORDS=256):
  - Load 0x12 → err = 1, rdata = 0.
  - Store to 0x400 → err = 1; a following load of 0x0 is unchanged.
- LATENCY=0, back-to-back requests with req_valid_i held high:
  - Accepts occur on every second edge.
  - resp_valid_o pulses in the cycle after each accept.
- rst_i pulled low during WAIT of a store to 0x20 (old value 0x11111111):
  - Outputs reach reset values immediately and no response is produced.
  - A later load of 0x20 returns 0x11111111.
- Requester changes req_addr_i and req_wdata_i during WAIT:
  - The committed access uses the captured values.
  - resp_valid_o is asserted once only.
